// File: rtl/alu_exec_if.sv
// Operand/control bundle into the ALU execute stage and its registered results.
interface alu_exec_if;
  logic        in_valid;
  logic [1:0]  aluop;
  logic [3:0]  funct;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] pc;
  logic [31:0] br_offset;
  logic        out_valid;
  logic [31:0] result;
  logic        zout;
  logic        nout;
  logic        cout;
  logic        ovf;
  logic [2:0]  gout;
  logic [31:0] pc_plus4;
  logic [31:0] br_target;

  modport master (
    output in_valid, aluop, funct, src_a, src_b, pc, br_offset,
    input  out_valid, result, zout, nout, cout, ovf, gout, pc_plus4, br_target
  );

  modport slave (
    input  in_valid, aluop, funct, src_a, src_b, pc, br_offset,
    output out_valid, result, zout, nout, cout, ovf, gout, pc_plus4, br_target
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Single-cycle ALU execute stage: operation decode, ALU with flags, and
// next-pc / branch-target adders, all results registered.
module alu_exec_unit #(
  parameter logic [31:0] PC_STEP = 32'h4
) (
  input  logic        clk,
  input  logic        rst,
  alu_exec_if.slave   bus
);

  logic [2:0]  op;
  logic [32:0] add_w;
  logic [32:0] sub_w;
  logic [31:0] alu_res;
  logic        alu_c;
  logic        alu_v;
  logic [31:0] pc4;

  // Later funct matches override earlier ones.
  always_comb begin
    op = 3'b010;
    if (bus.aluop[1]) begin
      if (bus.funct[3] && bus.funct[1])  op = 3'b111;
      if (!bus.funct[3] && bus.funct[1]) op = 3'b110;
      if (bus.funct[2] && bus.funct[0])  op = 3'b001;
      if (bus.funct[2] && !bus.funct[0]) op = 3'b000;
    end else if (bus.aluop[0]) begin
      op = 3'b110;
    end
  end

  assign add_w = {1'b0, bus.src_a} + {1'b0, bus.src_b};
  assign sub_w = {1'b0, bus.src_a} - {1'b0, bus.src_b};

  always_comb begin
    alu_res = 32'h0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (op)
      3'b010: begin
        alu_res = add_w[31:0];
        alu_c   = add_w[32];
        alu_v   = (bus.src_a[31] == bus.src_b[31]) && (add_w[31] != bus.src_a[31]);
      end
      3'b110: begin
        alu_res = sub_w[31:0];
        alu_c   = ~sub_w[32];
        alu_v   = (bus.src_a[31] != bus.src_b[31]) && (sub_w[31] != bus.src_a[31]);
      end
      3'b000: alu_res = bus.src_a & bus.src_b;
      3'b001: alu_res = bus.src_a | bus.src_b;
      3'b111: alu_res = ($signed(bus.src_a) < $signed(bus.src_b)) ? 32'h1 : 32'h0;
      default: alu_res = 32'h0;
    endcase
  end

  assign pc4 = bus.pc + PC_STEP;

  logic        out_valid_q;
  logic [31:0] result_q;
  logic        zout_q;
  logic        nout_q;
  logic        cout_q;
  logic        ovf_q;
  logic [2:0]  gout_q;
  logic [31:0] pc_plus4_q;
  logic [31:0] br_target_q;

  // Reset leaves zout set so the flags agree with the zeroed result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= 32'h0;
      zout_q      <= 1'b1;
      nout_q      <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      gout_q      <= 3'b000;
      pc_plus4_q  <= 32'h0;
      br_target_q <= 32'h0;
    end else if (bus.in_valid) begin
      out_valid_q <= 1'b1;
      result_q    <= alu_res;
      zout_q      <= (alu_res == 32'h0);
      nout_q      <= alu_res[31];
      cout_q      <= alu_c;
      ovf_q       <= alu_v;
      gout_q      <= op;
      pc_plus4_q  <= pc4;
      br_target_q <= pc4 + bus.br_offset;
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zout      = zout_q;
  assign bus.nout      = nout_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.gout      = gout_q;
  assign bus.pc_plus4  = pc_plus4_q;
  assign bus.br_target = br_target_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed and random checks of alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_exec_if bus ();
  alu_exec_unit #(.PC_STEP(32'h4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  logic        m_valid;
  logic [31:0] m_result;
  logic        m_z, m_n, m_c, m_v;
  logic [2:0]  m_g;
  logic [31:0] m_pc4, m_bt;

  function automatic logic [2:0] ref_op(logic [1:0] aop, logic [3:0] f);
    if (aop == 2'b00) return 3'b010;
    if (aop == 2'b01) return 3'b110;
    // Highest-priority rule checked first.
    if (f[2] && !f[0]) return 3'b000;
    if (f[2] && f[0])  return 3'b001;
    if (!f[3] && f[1]) return 3'b110;
    if (f[3] && f[1])  return 3'b111;
    return 3'b010;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_result = 32'h0; m_z = 1'b1; m_n = 1'b0; m_c = 1'b0;
    m_v = 1'b0; m_g = 3'b000; m_pc4 = 32'h0; m_bt = 32'h0;
  endtask

  task automatic model_step(logic inv, logic [1:0] aop, logic [3:0] f, logic [31:0] a,
                            logic [31:0] b, logic [31:0] pc, logic [31:0] off);
    longint sa, sb, s, ua, ub;
    if (!inv) begin
      m_valid = 1'b0;
      return;
    end
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    m_g = ref_op(aop, f);
    m_c = 1'b0;
    m_v = 1'b0;
    case (m_g)
      3'b010: begin
        m_result = a + b;
        m_c = (ua + ub) > 64'sd4294967295;
        s = sa + sb;
        m_v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'b110: begin
        m_result = a - b;
        m_c = (ua >= ub);
        s = sa - sb;
        m_v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'b000: m_result = a & b;
      3'b001: m_result = a | b;
      3'b111: m_result = (sa < sb) ? 32'h1 : 32'h0;
      default: m_result = 32'h0;
    endcase
    m_valid = 1'b1;
    m_z = (m_result == 32'h0);
    m_n = m_result[31];
    m_pc4 = pc + 32'h4;
    m_bt = m_pc4 + off;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".valid"},  32'(bus.out_valid), 32'(m_valid));
    chk({tag, ".result"}, bus.result,         m_result);
    chk({tag, ".z"},      32'(bus.zout),      32'(m_z));
    chk({tag, ".n"},      32'(bus.nout),      32'(m_n));
    chk({tag, ".c"},      32'(bus.cout),      32'(m_c));
    chk({tag, ".v"},      32'(bus.ovf),       32'(m_v));
    chk({tag, ".g"},      32'(bus.gout),      32'(m_g));
    chk({tag, ".pc4"},    bus.pc_plus4,       m_pc4);
    chk({tag, ".bt"},     bus.br_target,      m_bt);
  endtask

  task automatic step(string tag, logic inv, logic [1:0] aop, logic [3:0] f, logic [31:0] a,
                      logic [31:0] b, logic [31:0] pc, logic [31:0] off);
    bus.in_valid = inv; bus.aluop = aop; bus.funct = f; bus.src_a = a;
    bus.src_b = b; bus.pc = pc; bus.br_offset = off;
    @(posedge clk);
    model_step(inv, aop, f, a, b, pc, off);
    #1;
    check_all(tag);
  endtask

  task automatic pulse_reset(string tag);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.aluop = 2'b00; bus.funct = 4'h0; bus.src_a = 32'h0;
    bus.src_b = 32'h0; bus.pc = 32'h0; bus.br_offset = 32'h0;
    model_reset();
    #2;
    check_all("reset_async");
    @(negedge clk);
    rst = 1'b0;

    step("add5_3", 1'b1, 2'b00, 4'h0, 32'd5, 32'd3, 32'h100, 32'h20);
    chk("add5_3.const", bus.result, 32'd8);
    step("sub7_7", 1'b1, 2'b01, 4'h0, 32'd7, 32'd7, 32'h104, 32'h0);
    chk("sub7_7.zconst", 32'(bus.zout), 32'd1);
    step("sub0_1", 1'b1, 2'b01, 4'h0, 32'd0, 32'd1, 32'h108, 32'hFFFF_FFF0);
    chk("sub0_1.const", bus.result, 32'hFFFF_FFFF);
    step("and", 1'b1, 2'b10, 4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 32'h4);
    chk("and.const", bus.result, 32'hF000_F000);
    step("or", 1'b1, 2'b10, 4'b0101, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 32'h4);
    chk("or.const", bus.result, 32'hFFF0_FFF0);
    step("slt_t", 1'b1, 2'b10, 4'b1010, 32'hFFFF_FFFF, 32'h1, 32'h40, 32'h0);
    chk("slt_t.const", 32'(bus.gout), 32'd7);
    step("slt_f", 1'b1, 2'b10, 4'b1010, 32'h1, 32'hFFFF_FFFF, 32'h40, 32'h0);
    step("ovf_wrap", 1'b1, 2'b00, 4'h0, 32'h7FFF_FFFF, 32'h1, 32'hFFFF_FFFC, 32'h8);
    chk("ovf_wrap.pc4", bus.pc_plus4, 32'h0);
    chk("ovf_wrap.bt", bus.br_target, 32'h8);
    step("funct0010", 1'b1, 2'b10, 4'b0010, 32'h10, 32'h20, 32'h0, 32'h0);
    step("funct1110", 1'b1, 2'b10, 4'b1110, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0, 32'h0);
    step("funct1000", 1'b1, 2'b11, 4'b1000, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0);
    step("hold", 1'b0, 2'b01, 4'h0, 32'h1234, 32'h5, 32'h200, 32'h0);
    step("valid_again", 1'b1, 2'b01, 4'h0, 32'h8000_0000, 32'h1, 32'h200, 32'h0);

    pulse_reset("reset_mid");
    step("post_rst_idle", 1'b0, 2'b00, 4'h0, 32'h9, 32'h9, 32'h0, 32'h0);
    step("post_rst_first", 1'b1, 2'b00, 4'h0, 32'h9, 32'h9, 32'h0, 32'h0);

    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)), $urandom, $urandom, $urandom, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
